// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: N-way round-robin arbiter, registered one-hot grant. Rev 1.0
// Optional burst/hold mode compiled in with RR_ARBITER_PARAM_HOLD_EN.
`default_nettype none

module rr_arbiter_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  localparam int IW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("rr_arbiter_param: N out of range 2..32");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_param: MAX_HOLD out of range 1..255");
  end

  logic [IW-1:0] ptr;
  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] arb_id;
  logic          arb_found;
  logic [IW:0]   sum;
  logic [IW-1:0] pos;
  logic [IW-1:0] next_ptr;
  logic          hold;
  logic [N-1:0]  d_gnt;
  logic [IW-1:0] d_id;

  // Scan from ptr upward, wrapping at N so no index >= N is ever produced.
  always_comb begin
    arb_gnt   = '0;
    arb_id    = '0;
    arb_found = 1'b0;
    sum       = '0;
    pos       = '0;
    for (int o = 0; o < N; o++) begin
      sum = {1'b0, ptr} + (IW+1)'(o);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (!arb_found && req[pos]) begin
        arb_found    = 1'b1;
        arb_gnt[pos] = 1'b1;
        arb_id       = pos;
      end
    end
  end

  assign next_ptr = (arb_id == IW'(N-1)) ? '0 : arb_id + 1'b1;

`ifdef RR_ARBITER_PARAM_HOLD_EN
  localparam int HW = (MAX_HOLD + 1 > 2) ? $clog2(MAX_HOLD + 1) : 1;

  logic [HW-1:0] hold_cnt;

  // Current owner keeps the grant while still requesting and under its burst limit.
  assign hold = (|(gnt & req)) && (hold_cnt < HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (hold) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign hold = 1'b0;
`endif

  assign d_gnt = hold ? gnt    : arb_gnt;
  assign d_id  = hold ? gnt_id : arb_id;

  // ptr follows the combinational winner so the winner is last in next cycle's order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
    end else begin
      gnt       <= d_gnt;
      gnt_valid <= |d_gnt;
      gnt_id    <= d_id;
      if (!hold && arb_found) ptr <= next_ptr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_param.sv
// tb_rr_arbiter_param: table vectors, corner sequences and a randomized model comparison.
`default_nettype none

module tb_rr_arbiter_param;

`ifdef RR_ARBITER_PARAM_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req4, gnt4;  logic gv4; logic [1:0] id4;
  logic [4:0] req5, gnt5;  logic gv5; logic [2:0] id5;
  logic [3:0] reqh, gnth;  logic gvh; logic [1:0] idh;
  logic [6:0] req7, gnt7;  logic gv7; logic [2:0] id7;

  rr_arbiter_param #(.N(4), .MAX_HOLD(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .gnt_valid(gv4), .gnt_id(id4));
  rr_arbiter_param #(.N(5), .MAX_HOLD(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .gnt(gnt5), .gnt_valid(gv5), .gnt_id(id5));
  rr_arbiter_param #(.N(4), .MAX_HOLD(3)) duth (
    .clk(clk), .rst_n(rst_n), .req(reqh), .gnt(gnth), .gnt_valid(gvh), .gnt_id(idh));
  rr_arbiter_param #(.N(7), .MAX_HOLD(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .req(req7), .gnt(gnt7), .gnt_valid(gv7), .gnt_id(id7));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: abstract owner/burst bookkeeping, circular search with modulo.
  typedef struct {
    int ptr;
    int owner;
    int run;
  } mstate_t;

  function automatic int model_arb(input int n, input int maxh, input bit hold_en,
                                   input logic [31:0] r, input mstate_t s, output mstate_t ns);
    int i;
    ns = s;
    if (hold_en && s.owner >= 0 && r[s.owner] && s.run < maxh) begin
      ns.run = s.run + 1;
      return s.owner;
    end
    for (int k = 0; k < n; k++) begin
      i = (s.ptr + k) % n;
      if (r[i]) begin
        ns.ptr   = (i + 1) % n;
        ns.owner = i;
        ns.run   = 1;
        return i;
      end
    end
    ns.owner = -1;
    ns.run   = 0;
    return -1;
  endfunction

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
  } vec_t;

  vec_t        tbl [18];
  mstate_t     ms, mn;
  int          g;
  int          maxwait;
  int          waitc [7];
  logic [6:0]  r7;
  logic [31:0] expv;
  logic [3:0]  hexp;

  initial begin
    tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0001, 2'd0};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0010, 2'd1};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0100, 2'd2};
    tbl[4]  = '{1'b1, 4'b1111, 4'b1000, 2'd3};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0001, 2'd0};
    tbl[6]  = '{1'b1, 4'b0101, 4'b0100, 2'd2};
    tbl[7]  = '{1'b1, 4'b0101, 4'b0001, 2'd0};
    tbl[8]  = '{1'b1, 4'b0101, 4'b0100, 2'd2};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0};
    tbl[10] = '{1'b1, 4'b0110, 4'b0010, 2'd1};
    tbl[11] = '{1'b1, 4'b1111, 4'b0100, 2'd2};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 2'd0};
    tbl[13] = '{1'b1, 4'b1111, 4'b0001, 2'd0};
    tbl[14] = '{1'b1, 4'b1000, 4'b1000, 2'd3};
    tbl[15] = '{1'b1, 4'b1000, 4'b1000, 2'd3};
    tbl[16] = '{1'b1, 4'b0001, 4'b0001, 2'd0};
    tbl[17] = '{1'b1, 4'b0000, 4'b0000, 2'd0};

    rst_n = 1'b0;
    req4 = '0; req5 = '0; reqh = '0; req7 = '0;
    tick;

    // N=4 table: round robin, alternation, idle, mid-sequence reset, sole requester.
    for (int v = 0; v < 18; v++) begin
      rst_n = tbl[v].rst;
      req4  = tbl[v].req;
      tick;
      check("tbl_gnt",   v, {28'b0, gnt4}, {28'b0, tbl[v].gnt});
      check("tbl_valid", v, {31'b0, gv4},  {31'b0, |tbl[v].gnt});
      check("tbl_id",    v, {30'b0, id4},  {30'b0, tbl[v].id});
    end
    req4 = '0;

    // N=5 wrap: bring ptr to 4, then requesters 4 and 0 alternate across the wrap.
    rst_n = 1'b0; tick; rst_n = 1'b1;
    req5 = 5'b01000; tick;
    check("n5_first", 0, {27'b0, gnt5}, 32'h08);
    req5 = 5'b10001; tick;
    check("n5_gnt", 1, {27'b0, gnt5}, 32'h10);
    check("n5_id",  1, {29'b0, id5},  32'd4);
    tick;
    check("n5_gnt", 2, {27'b0, gnt5}, 32'h01);
    check("n5_id",  2, {29'b0, id5},  32'd0);
    tick;
    check("n5_gnt", 3, {27'b0, gnt5}, 32'h10);
    req5 = '0;

    // N=4, MAX_HOLD=3: bursts of three with hold compiled in, plain alternation otherwise.
    rst_n = 1'b0; tick; rst_n = 1'b1;
    reqh = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      tick;
      if (HOLD_EN) hexp = (((c / 3) % 2) == 0) ? 4'b0001 : 4'b0010;
      else         hexp = ((c % 2) == 0) ? 4'b0001 : 4'b0010;
      check("hold_seq", c, {28'b0, gnth}, {28'b0, hexp});
    end
    rst_n = 1'b0; tick; rst_n = 1'b1;
    reqh = 4'b0011; tick;
    check("hold_drop_a", 0, {28'b0, gnth}, 32'h1);
    reqh = 4'b0010; tick;
    check("hold_drop_b", 0, {28'b0, gnth}, 32'h2);
    reqh = 4'b0011; tick;
    rst_n = 1'b0; tick;
    check("hold_rst", 0, {27'b0, gvh, gnth}, 32'h0);
    rst_n = 1'b1; tick;
    check("hold_rel", 0, {28'b0, gnth}, 32'h1);
    reqh = '0;

    // N=7 randomized sticky requests against the reference model.
    rst_n = 1'b0; tick; rst_n = 1'b1;
    ms = '{0, -1, 0};
    r7 = '0;
    maxwait = 0;
    for (int b = 0; b < 7; b++) waitc[b] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(7) == 0) r7[b] = ~r7[b];
      req7 = r7;
      g = model_arb(7, 3, HOLD_EN, {25'b0, r7}, ms, mn);
      tick;
      expv = (g < 0) ? 32'h0 : (32'h1 << g);
      check("rand_gnt",   c, {25'b0, gnt7}, expv);
      check("rand_id",    c, {29'b0, id7},  (g < 0) ? 32'd0 : g);
      check("rand_valid", c, {31'b0, gv7},  {31'b0, (g >= 0)});
      check("rand_onehot", c, {31'b0, $onehot0(gnt7)}, 32'd1);
      for (int b = 0; b < 7; b++) begin
        if (r7[b] && !gnt7[b]) waitc[b]++;
        else                   waitc[b] = 0;
        if (waitc[b] > maxwait) maxwait = waitc[b];
      end
      ms = mn;
    end
    check("rand_fair", maxwait, {31'b0, (maxwait < (HOLD_EN ? 7 * 3 : 7))}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arbiter_param.md
RR_ARBITER_PARAM -- requirements
Module: rr_arbiter_param

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..32.
REQ-002 Parameter MAX_HOLD, default 4, max consecutive grant cycles per owner when hold is enabled; legal range 1..255.
REQ-003 Derived localparam IW = clog2(N), minimum 1; HW = clog2(MAX_HOLD+1), minimum 1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  N  request vector; bit i = requester i; no handshake beyond level.
REQ-007 gnt  output  N  registered grant; one-hot or all-zero.
REQ-008 gnt_valid  output  1  registered; equals OR of gnt.
REQ-009 gnt_id  output  IW  registered binary index of the set gnt bit; 0 when gnt_valid=0.

Function
REQ-010 Priority pointer ptr (IW bits) SHALL name the highest-priority index; search order ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
REQ-011 Next grant d_gnt SHALL be the first set req bit in search order; all-zero when req=0.
REQ-012 gnt, gnt_valid, gnt_id SHALL load d_gnt-derived values each cycle; latency req sample -> gnt = 1 cycle.
REQ-013 ptr SHALL update in the same edge as gnt, from d_gnt (not from registered gnt): on new grant to index k, ptr <= (k+1) mod N.
REQ-014 Requester granted at edge t SHALL NOT be first in search order at edge t+1; a competitor with req high SHALL win at t+1 (no double grant from pointer lag).
REQ-015 req=0: gnt <= 0, ptr unchanged.
REQ-016 Wrap: k=N-1 -> ptr <= 0; N not power of two SHALL wrap at N, never reaching indices >= N.
REQ-017 Sole continuous requester SHALL receive grant every cycle.
REQ-018 Grant reflects req sampled at the previous edge; req dropping after sampling does not revoke the already-registered grant.
REQ-019 gnt SHALL never have more than one bit set; gnt_id SHALL always match gnt.

Reset
REQ-020 rst_n=0 at an edge: gnt=0, gnt_valid=0, gnt_id=0, ptr=0, hold_cnt=0, overriding all other updates.
REQ-021 Reset asserted mid-hold SHALL abandon the hold; first arbitration after release starts from ptr=0.
REQ-022 No output SHALL depend combinationally on rst_n.

Configuration
REQ-023 Macro RR_ARBITER_PARAM_HOLD_EN compiles in grant hold (burst) mode.
REQ-024 With macro: counter hold_cnt (HW bits); when gnt[i]=1, req[i]=1 and hold_cnt < MAX_HOLD-1, d_gnt SHALL equal gnt, hold_cnt increments, ptr unchanged.
REQ-025 With macro: owner releases when req[i]=0 or hold_cnt = MAX_HOLD-1; then normal arbitration with ptr=(i+1) mod N, hold_cnt <= 0.
REQ-026 With macro, MAX_HOLD=1 SHALL behave identically to macro absent.
REQ-027 Without macro: no hold_cnt, re-arbitration every cycle per REQ-010..REQ-019.

Verification
REQ-028 N=4, reset, req=4'b1111 constant, no hold -> gnt 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-029 N=4, req=4'b0101 constant -> gnt alternates 0001,0100; never 0001 twice in a row.
REQ-030 N=5, req=5'b10001, ptr at 4 -> gnt 10000 then 00001; ptr wraps to 0 then 1; gnt_id 4 then 0.
REQ-031 HOLD_EN, MAX_HOLD=3, N=4, req=4'b0011 constant -> gnt 0001 x3, 0010 x3, 0001 x3; req[0] dropped after 1 grant cycle -> 0010 next cycle.
REQ-032 rst_n low for 1 cycle mid-sequence with req=4'b1111 -> outputs 0 next cycle; after release gnt=0001.
REQ-033 Random req for 10k cycles, N=7 -> gnt one-hot/zero, gnt_id consistent, each continuous requester granted within N cycles (N*MAX_HOLD with hold).
